sobel_axi_burst_reader: RTL and testbench
=========================================

Name: sobel_axi_burst_reader

Overview:
AXI4 full-protocol read master (initiator side) that fetches a source image from DDR for the Sobel pipeline. The Sobel slave port is written by the host, and this master lets the core pull pixels itself. Software programs a base address and word count and pulses start. The block issues INCR read bursts that never cross a 4 KB boundary and forwards R-channel data as a valid/ready pixel stream, with tlast on the final word.

Parameters:
C_M00_AXI_ID_WIDTH, 5, width of ARID/RID
C_M00_AXI_ADDR_WIDTH, 32, byte address width
C_M00_AXI_DATA_WIDTH, 32, data width; only 32 supported
C_MAX_BURST, 16, max beats per burst (1..256)
C_LEN_WIDTH, 24, width of the word-count input

Ports:
m00_axi_aclk  in  1  clock; all logic on rising edge
m00_axi_areset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
base_addr  in  ADDR_WIDTH  byte address; bits [1:0] forced to 0
num_words  in  C_LEN_WIDTH  number of 32-bit words to read
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of transfer
error  out  1  sticky; cleared on the next accepted start
m00_axi_arid  out  ID_WIDTH  constant 0
m00_axi_araddr  out  ADDR_WIDTH  burst start address
m00_axi_arlen  out  8  beats-1
m00_axi_arsize  out  3  constant 3'b010
m00_axi_arburst  out  2  constant 2'b01 (INCR)
m00_axi_arlock/arcache/arprot/arqos  out  1/4/3/4  constants 0/4'b0011/0/0
m00_axi_arvalid  out  1  address valid
m00_axi_arready  in  1  address accepted
m00_axi_rid  in  ID_WIDTH  ignored
m00_axi_rdata  in  DATA_WIDTH  read data
m00_axi_rresp  in  2  response
m00_axi_rlast  in  1  last beat of burst
m00_axi_rvalid  in  1  data valid
m00_axi_rready  out  1  data accept
px_tdata  out  32  pixel word
px_tvalid  out  1  stream valid
px_tready  in  1  stream backpressure
px_tlast  out  1  final word of the whole transfer

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, error, arvalid, araddr, arlen all 0; counters 0. Mid-transfer reset abandons the transfer with no AXI cleanup.
- States: IDLE, ADDR, DATA, DONE.
- IDLE:
  - start=1 with num_words>0: latch addr and remaining count, clear error, set busy, go to ADDR.
  - start=1 with num_words=0: go to DONE; no AXI traffic.
- Burst sizing (registered on entry to ADDR): beats = min(remaining, C_MAX_BURST, 1024 - addr[11:2]); arlen = beats-1.
- ADDR:
  - arvalid=1 held with araddr/arlen stable until arready.
  - On handshake, arvalid drops in the same cycle edge; go to DATA.
  - Exactly one burst is outstanding at a time.
- DATA, zero-latency pass-through:
  - px_tdata = rdata; px_tvalid = rvalid; rready = px_tready. Both are gated to 0 outside DATA.
  - Beat counter increments on rvalid & rready.
  - px_tlast = 1 on the beat where remaining==1.
- Error conditions (all set sticky error; data is still forwarded and counting continues):
  - rresp != 2'b00 on any beat.
  - rlast disagreeing with beat counter, in either direction.
- End of burst:
  - After the counted final beat: addr += beats*4; remaining -= beats.
  - remaining>0 → ADDR; else → DONE. Burst end is decided by the beat counter, not rlast.
- DONE: done=1 for exactly one cycle; busy=0 in the same cycle; → IDLE.
- start while busy or in DONE: ignored.
- Throughput: back-to-back bursts have a 1-cycle ADDR gap minimum. Within a burst, 1 word/cycle when px_tready=1.

Decomposition:
- Package sobel_axi_pkg:
  - AXI constants: BURST_INCR=2'b01, SIZE_4B=3'b010, RESP_OKAY=2'b00, CACHE_DEFAULT=4'b0011, BOUNDARY_WORDS=1024.
  - Reader state enum.
- One natural sub-module: sobel_burst_len_calc. Combinational min(remaining, C_MAX_BURST, words to 4 KB) → arlen; unit-testable on its own.

Test Plan:
- base=0x1000_0000, num_words=40, C_MAX_BURST=16, arready/px_tready always 1 → ARs at 0x1000_0000/0x1000_0040/0x1000_0080 with arlen 15/15/7; 40 words in order; px_tlast only on word 40; done pulse; error=0.
- base=0x1000_0FF0, num_words=8 → first AR arlen=3 at 0x1000_0FF0, second AR arlen=3 at 0x1000_1000; no burst crosses 4 KB.
- num_words=0 with start → done pulses 2 cycles after start; arvalid never asserted.
- px_tready toggling 1,0,0,1 repeated, 16-beat burst → rready mirrors px_tready; no word lost or duplicated; all 16 words match memory model.
- Slave returns rresp=2'b10 on beat 3 and early rlast on beat 14 of 16 → error=1 after beat 3; transfer still completes; error cleared on next start.
- Assert reset during DATA beat 5 → next cycle busy=0, arvalid=0, rready=0, state IDLE; fresh start of 4 words completes normally.

Source files
------------

// File: rtl/sobel_axi_pkg.sv
// Shared AXI constants and reader state encoding
// for the Sobel DDR burst reader.
package sobel_axi_pkg;

    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [2:0] SIZE_4B       = 3'b010;
    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
    localparam int         BOUNDARY_WORDS = 1024;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DONE
    } rd_state_t;

endpackage

// File: rtl/sobel_burst_len_calc.sv
// Burst sizing: min(remaining, max burst, words left
// before the next 4 KB page), returned as beats and arlen.
module sobel_burst_len_calc
    import sobel_axi_pkg::*;
#(
    parameter int C_LEN_WIDTH = 24,
    parameter int C_MAX_BURST = 16
) (
    input  logic [9:0]             word_off,
    input  logic [C_LEN_WIDTH-1:0] remaining,
    output logic [8:0]             beats,
    output logic [7:0]             arlen
);

    localparam int CW = (C_LEN_WIDTH > 11) ? C_LEN_WIDTH : 11;

    logic [10:0]   to_bound;
    logic [CW-1:0] rem_w;
    logic [CW-1:0] max_w;
    logic [CW-1:0] bound_w;
    logic [CW-1:0] m1;
    logic [CW-1:0] m2;

    // Three-way minimum; the page term is 1..1024 words
    always_comb begin
        to_bound = 11'(BOUNDARY_WORDS) - {1'b0, word_off};
        rem_w    = CW'(remaining);
        max_w    = CW'(C_MAX_BURST);
        bound_w  = CW'(to_bound);
        m1       = (rem_w < max_w) ? rem_w : max_w;
        m2       = (m1 < bound_w) ? m1 : bound_w;
        beats    = 9'(m2);
        arlen    = 8'(m2 - CW'(1));
    end

endmodule

// File: rtl/sobel_axi_burst_reader.sv
// AXI4 read master: fetches num_words from DDR in INCR
// bursts that never cross 4 KB, streaming R data out.
module sobel_axi_burst_reader
    import sobel_axi_pkg::*;
#(
    parameter int C_M00_AXI_ID_WIDTH   = 5,
    parameter int C_M00_AXI_ADDR_WIDTH = 32,
    parameter int C_M00_AXI_DATA_WIDTH = 32,
    parameter int C_MAX_BURST          = 16,
    parameter int C_LEN_WIDTH          = 24
) (
    input  logic                            m00_axi_aclk,
    input  logic                            m00_axi_areset,
    input  logic                            start,
    input  logic [C_M00_AXI_ADDR_WIDTH-1:0] base_addr,
    input  logic [C_LEN_WIDTH-1:0]          num_words,
    output logic                            busy,
    output logic                            done,
    output logic                            error,
    output logic [C_M00_AXI_ID_WIDTH-1:0]   m00_axi_arid,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0] m00_axi_araddr,
    output logic [7:0]                      m00_axi_arlen,
    output logic [2:0]                      m00_axi_arsize,
    output logic [1:0]                      m00_axi_arburst,
    output logic                            m00_axi_arlock,
    output logic [3:0]                      m00_axi_arcache,
    output logic [2:0]                      m00_axi_arprot,
    output logic [3:0]                      m00_axi_arqos,
    output logic                            m00_axi_arvalid,
    input  logic                            m00_axi_arready,
    input  logic [C_M00_AXI_ID_WIDTH-1:0]   m00_axi_rid,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0] m00_axi_rdata,
    input  logic [1:0]                      m00_axi_rresp,
    input  logic                            m00_axi_rlast,
    input  logic                            m00_axi_rvalid,
    output logic                            m00_axi_rready,
    output logic [31:0]                     px_tdata,
    output logic                            px_tvalid,
    input  logic                            px_tready,
    output logic                            px_tlast
);

    localparam int AW = C_M00_AXI_ADDR_WIDTH;
    localparam int LW = C_LEN_WIDTH;

    rd_state_t state_q, state_n;

    logic [AW-1:0] addr_q, addr_n;
    logic [LW-1:0] rem_q, rem_n;
    logic [8:0]    cnt_q, cnt_n;
    logic [8:0]    beats_q;
    logic [7:0]    arlen_q;
    logic          err_q, err_n;

    logic [8:0] calc_beats;
    logic [7:0] calc_arlen;
    logic       in_data;
    logic       beat;
    logic       last_beat;
    logic       unused_ok;

    assign unused_ok = ^m00_axi_rid;

    // Size the next burst from the values being loaded
    sobel_burst_len_calc #(
        .C_LEN_WIDTH (LW),
        .C_MAX_BURST (C_MAX_BURST)
    ) u_len (
        .word_off  (addr_n[11:2]),
        .remaining (rem_n),
        .beats     (calc_beats),
        .arlen     (calc_arlen)
    );

    assign in_data   = (state_q == S_DATA);
    assign beat      = in_data & m00_axi_rvalid & px_tready;
    assign last_beat = (cnt_q == beats_q - 9'd1);

    // State register
    always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
        if (m00_axi_areset) state_q <= S_IDLE;
        else                state_q <= state_n;
    end

    // Next state plus address, count and error updates
    always_comb begin
        state_n = state_q;
        addr_n  = addr_q;
        rem_n   = rem_q;
        cnt_n   = cnt_q;
        err_n   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_n = 1'b0;
                    if (num_words != '0) begin
                        addr_n  = {base_addr[AW-1:2], 2'b00};
                        rem_n   = num_words;
                        cnt_n   = '0;
                        state_n = S_ADDR;
                    end else begin
                        state_n = S_DONE;
                    end
                end
            end
            S_ADDR: begin
                if (m00_axi_arready) state_n = S_DATA;
            end
            S_DATA: begin
                if (beat) begin
                    cnt_n = cnt_q + 9'd1;
                    if (m00_axi_rresp != RESP_OKAY) err_n = 1'b1;
                    if (m00_axi_rlast != last_beat) err_n = 1'b1;
                    if (last_beat) begin
                        addr_n  = addr_q + AW'({beats_q, 2'b00});
                        rem_n   = rem_q - LW'(beats_q);
                        cnt_n   = '0;
                        state_n = (rem_n != '0) ? S_ADDR : S_DONE;
                    end
                end
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Datapath registers; burst size latched on ADDR entry
    always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
        if (m00_axi_areset) begin
            addr_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            beats_q <= '0;
            arlen_q <= '0;
        end else begin
            addr_q <= addr_n;
            rem_q  <= rem_n;
            cnt_q  <= cnt_n;
            err_q  <= err_n;
            if (state_n == S_ADDR && state_q != S_ADDR) begin
                beats_q <= calc_beats;
                arlen_q <= calc_arlen;
            end
        end
    end

    assign busy  = (state_q == S_ADDR) || in_data;
    assign done  = (state_q == S_DONE);
    assign error = err_q;

    assign m00_axi_arid    = '0;
    assign m00_axi_araddr  = addr_q;
    assign m00_axi_arlen   = arlen_q;
    assign m00_axi_arsize  = SIZE_4B;
    assign m00_axi_arburst = BURST_INCR;
    assign m00_axi_arlock  = 1'b0;
    assign m00_axi_arcache = CACHE_DEFAULT;
    assign m00_axi_arprot  = 3'b000;
    assign m00_axi_arqos   = 4'b0000;
    assign m00_axi_arvalid = (state_q == S_ADDR);

    assign m00_axi_rready = in_data & px_tready;
    assign px_tvalid      = in_data & m00_axi_rvalid;
    assign px_tdata       = in_data ? m00_axi_rdata : '0;
    assign px_tlast       = in_data & last_beat
                          & (rem_q == LW'(beats_q));

endmodule

// File: tb/tb_sobel_axi_burst_reader.sv
// Directed bench for sobel_axi_burst_reader with a
// one-outstanding AXI read slave and pixel sink.
module tb_sobel_axi_burst_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [23:0] num_words;
    logic        busy, done, error;
    logic [4:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic [3:0]  arqos;
    logic        arvalid, arready;
    logic [4:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic [31:0] px_tdata;
    logic        px_tvalid, px_tready, px_tlast;

    sobel_axi_burst_reader dut (
        .m00_axi_aclk    (clk),
        .m00_axi_areset  (rst),
        .start           (start),
        .base_addr       (base_addr),
        .num_words       (num_words),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .m00_axi_arid    (arid),
        .m00_axi_araddr  (araddr),
        .m00_axi_arlen   (arlen),
        .m00_axi_arsize  (arsize),
        .m00_axi_arburst (arburst),
        .m00_axi_arlock  (arlock),
        .m00_axi_arcache (arcache),
        .m00_axi_arprot  (arprot),
        .m00_axi_arqos   (arqos),
        .m00_axi_arvalid (arvalid),
        .m00_axi_arready (arready),
        .m00_axi_rid     (rid),
        .m00_axi_rdata   (rdata),
        .m00_axi_rresp   (rresp),
        .m00_axi_rlast   (rlast),
        .m00_axi_rvalid  (rvalid),
        .m00_axi_rready  (rready),
        .px_tdata        (px_tdata),
        .px_tvalid       (px_tvalid),
        .px_tready       (px_tready),
        .px_tlast        (px_tlast)
    );

    int tests = 0;
    int fails = 0;

    logic [31:0] ar_addr_q[$];
    int          ar_len_q[$];
    logic [31:0] px_q[$];
    bit          last_q[$];
    bit          err_q[$];
    int          done_cnt;
    bit          ever_ar;
    int          rr_mis;

    bit          use_pat;
    logic [3:0]  pat;
    int          cyc;
    int          bad_resp_beat;
    int          early_last_beat;

    bit          have_burst;
    logic [31:0] b_addr;
    int          b_len;
    int          b_idx;
    bit          fire_ar, fire_r;
    logic [31:0] s_araddr, s_px;
    logic [7:0]  s_arlen;
    bit          s_last;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[17:2]};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slave + sink agent: acts on negedges, sees posedge effects
    initial begin
        have_burst = 0; fire_ar = 0; fire_r = 0;
        b_addr = '0; b_len = 0; b_idx = 0; cyc = 0;
        s_araddr = '0; s_arlen = '0; s_px = '0; s_last = 0;
        arready = 0; rvalid = 0; rdata = '0; rresp = '0;
        rlast = 0; rid = '0; px_tready = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have_burst = 0;
            end else begin
                if (fire_ar) begin
                    ar_addr_q.push_back(s_araddr);
                    ar_len_q.push_back(int'(s_arlen));
                    have_burst = 1;
                    b_addr = s_araddr;
                    b_len = int'(s_arlen) + 1;
                    b_idx = 0;
                end
                if (fire_r) begin
                    px_q.push_back(s_px);
                    last_q.push_back(s_last);
                    err_q.push_back(error);
                    b_idx++;
                    if (b_idx >= b_len) have_burst = 0;
                end
            end
            if (done) done_cnt++;
            px_tready = use_pat ? pat[cyc % 4] : 1'b1;
            cyc++;
            arready = 1'b1;
            if (have_burst) begin
                rvalid = 1'b1;
                rdata = mem(b_addr + 32'(4 * b_idx));
                rresp = (b_idx + 1 == bad_resp_beat) ? 2'b10 : 2'b00;
                if (early_last_beat != 0)
                    rlast = (b_idx + 1 == early_last_beat);
                else
                    rlast = (b_idx + 1 == b_len);
            end else begin
                rvalid = 1'b0;
                rresp = 2'b00;
                rlast = 1'b0;
            end
            #1;
            fire_ar = !rst && arvalid && arready;
            fire_r = !rst && rvalid && rready;
            s_araddr = araddr;
            s_arlen = arlen;
            s_px = px_tdata;
            s_last = px_tlast;
            if (arvalid) ever_ar = 1;
            if (rvalid && (rready !== px_tready)) rr_mis++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic kick(input logic [31:0] b, input logic [23:0] n);
        ar_addr_q.delete(); ar_len_q.delete();
        px_q.delete(); last_q.delete(); err_q.delete();
        done_cnt = 0; ever_ar = 0; rr_mis = 0;
        base_addr = b;
        num_words = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (done_cnt != 0) begin
                ok = 1;
                break;
            end
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        tests++;
        if ({busy, done, error, arvalid} !== 4'b0) begin
            fails++;
            $display("FAIL reset_flags got %b want 0000",
                     {busy, done, error, arvalid});
        end
        tests++;
        if (araddr !== 32'h0 || arlen !== 8'h0) begin
            fails++;
            $display("FAIL reset_ar got %h/%h want 0/0", araddr, arlen);
        end
        tests++;
        if (arsize !== 3'b010 || arburst !== 2'b01 ||
            arcache !== 4'b0011 || arid !== 5'd0) begin
            fails++;
            $display("FAIL ar_consts got %b %b %b want 010 01 0011",
                     arsize, arburst, arcache);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_multi_burst();
        bit ok;
        logic [31:0] ea[3];
        int el[3];
        ea = '{32'h1000_0000, 32'h1000_0040, 32'h1000_0080};
        el = '{15, 15, 7};
        kick(32'h1000_0000, 24'd40);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL mb_busy got %b want 1", busy);
        end
        wait_done(ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL mb_timeout got no done want done");
        end
        tests++;
        if (ar_addr_q.size() != 3) begin
            fails++;
            $display("FAIL mb_ar_count got %0d want 3", ar_addr_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (ar_addr_q[i] !== ea[i] || ar_len_q[i] != el[i]) begin
                    fails++;
                    $display("FAIL mb_ar%0d got %h/%0d want %h/%0d", i,
                             ar_addr_q[i], ar_len_q[i], ea[i], el[i]);
                end
            end
        end
        tests++;
        if (px_q.size() != 40) begin
            fails++;
            $display("FAIL mb_words got %0d want 40", px_q.size());
        end else begin
            for (int i = 0; i < 40; i++) begin
                tests++;
                if (px_q[i] !== mem(32'h1000_0000 + 32'(4 * i)) ||
                    last_q[i] != (i == 39)) begin
                    fails++;
                    $display("FAIL mb_word%0d got %h/%0d want %h/%0d", i,
                             px_q[i], last_q[i],
                             mem(32'h1000_0000 + 32'(4 * i)), i == 39);
                end
            end
        end
        tests++;
        if (done_cnt != 1 || error !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mb_end got done=%0d err=%b busy=%b want 1 0 0",
                     done_cnt, error, busy);
        end
    endtask

    task automatic test_4k_boundary();
        bit ok;
        kick(32'h1000_0FF0, 24'd8);
        wait_done(ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL 4k_timeout got no done want done");
        end
        tests++;
        if (ar_addr_q.size() != 2) begin
            fails++;
            $display("FAIL 4k_ar_count got %0d want 2", ar_addr_q.size());
        end else begin
            tests++;
            if (ar_addr_q[0] !== 32'h1000_0FF0 || ar_len_q[0] != 3) begin
                fails++;
                $display("FAIL 4k_ar0 got %h/%0d want 10000ff0/3",
                         ar_addr_q[0], ar_len_q[0]);
            end
            tests++;
            if (ar_addr_q[1] !== 32'h1000_1000 || ar_len_q[1] != 3) begin
                fails++;
                $display("FAIL 4k_ar1 got %h/%0d want 10001000/3",
                         ar_addr_q[1], ar_len_q[1]);
            end
        end
        tests++;
        if (px_q.size() != 8 || px_q[7] !== mem(32'h1000_100C) ||
            last_q[7] != 1'b1) begin
            fails++;
            $display("FAIL 4k_data got n=%0d want 8 words ending %h",
                     px_q.size(), mem(32'h1000_100C));
        end
    endtask

    task automatic test_zero_len();
        kick(32'h5000_0000, 24'd0);
        tick();
        tests++;
        if (done_cnt != 1) begin
            fails++;
            $display("FAIL zero_done_early got %0d want 1", done_cnt);
        end
        repeat (4) tick();
        tests++;
        if (done_cnt != 1 || ever_ar || busy !== 1'b0) begin
            fails++;
            $display("FAIL zero_end got done=%0d ar=%0d busy=%b want 1 0 0",
                     done_cnt, ever_ar, busy);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int bad;
        use_pat = 1;
        pat = 4'b1001;
        kick(32'h2000_0000, 24'd16);
        wait_done(ok);
        use_pat = 0;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL bp_timeout got no done want done");
        end
        tests++;
        if (rr_mis != 0) begin
            fails++;
            $display("FAIL bp_rready got %0d mismatches want 0", rr_mis);
        end
        bad = 0;
        for (int i = 0; i < px_q.size(); i++)
            if (px_q[i] !== mem(32'h2000_0000 + 32'(4 * i))) bad++;
        tests++;
        if (px_q.size() != 16 || bad != 0) begin
            fails++;
            $display("FAIL bp_words got n=%0d bad=%0d want 16 0",
                     px_q.size(), bad);
        end
        tests++;
        if (ar_len_q.size() != 1 || last_q.size() != 16 ||
            last_q[15] != 1'b1) begin
            fails++;
            $display("FAIL bp_shape got ars=%0d want 1 AR and tlast on 16",
                     ar_len_q.size());
        end
    endtask

    task automatic test_errors();
        bit ok;
        bad_resp_beat = 3;
        early_last_beat = 14;
        kick(32'h3000_0000, 24'd16);
        wait_done(ok);
        bad_resp_beat = 0;
        early_last_beat = 0;
        tests++;
        if (!ok || px_q.size() != 16) begin
            fails++;
            $display("FAIL err_complete got ok=%0d n=%0d want 1 16",
                     ok, px_q.size());
        end else begin
            tests++;
            if (err_q[1] != 1'b0 || err_q[2] != 1'b1) begin
                fails++;
                $display("FAIL err_beat3 got %0d%0d want 01",
                         err_q[1], err_q[2]);
            end
            tests++;
            if (px_q[15] !== mem(32'h3000_003C)) begin
                fails++;
                $display("FAIL err_data got %h want %h",
                         px_q[15], mem(32'h3000_003C));
            end
        end
        tests++;
        if (error !== 1'b1) begin
            fails++;
            $display("FAIL err_sticky got %b want 1", error);
        end
        kick(32'h3000_1000, 24'd4);
        tests++;
        if (error !== 1'b0) begin
            fails++;
            $display("FAIL err_clear got %b want 0", error);
        end
        wait_done(ok);
        tests++;
        if (!ok || error !== 1'b0) begin
            fails++;
            $display("FAIL err_clean got ok=%0d err=%b want 1 0", ok, error);
        end
    endtask

    task automatic test_reset_mid_data();
        bit ok;
        kick(32'h4000_0000, 24'd32);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (px_q.size() >= 4) begin
                ok = 1;
                break;
            end
            tick();
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL rst_reach got %0d words want 4", px_q.size());
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({busy, arvalid, rready, px_tvalid} !== 4'b0) begin
            fails++;
            $display("FAIL rst_mid got %b want 0000",
                     {busy, arvalid, rready, px_tvalid});
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || arvalid !== 1'b0) begin
            fails++;
            $display("FAIL rst_idle got %b%b%b want 000",
                     busy, done, arvalid);
        end
        kick(32'h4000_0100, 24'd4);
        wait_done(ok);
        tests++;
        if (!ok || ar_addr_q.size() != 1 || px_q.size() != 4) begin
            fails++;
            $display("FAIL rst_fresh got ok=%0d ars=%0d n=%0d want 1 1 4",
                     ok, ar_addr_q.size(), px_q.size());
        end else begin
            tests++;
            if (ar_addr_q[0] !== 32'h4000_0100 || ar_len_q[0] != 3 ||
                px_q[3] !== mem(32'h4000_010C) || last_q[3] != 1'b1 ||
                last_q[2] != 1'b0) begin
                fails++;
                $display("FAIL rst_fresh_data got %h/%0d %h want %h/3 %h",
                         ar_addr_q[0], ar_len_q[0], px_q[3],
                         32'h4000_0100, mem(32'h4000_010C));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        num_words = '0;
        use_pat = 0;
        pat = 4'b1111;
        bad_resp_beat = 0;
        early_last_beat = 0;
        done_cnt = 0;
        ever_ar = 0;
        rr_mis = 0;
        test_reset();
        test_multi_burst();
        test_4k_boundary();
        test_zero_len();
        test_backpressure();
        test_errors();
        test_reset_mid_data();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
